// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per accepted load as start, 7/8 data,
// optional parity and stop bits on tx, always padding the frame to 11 bit times.
module uart_tx_engine #(
    parameter int BT_W = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [7:0]      out_data,
    input  logic            eight,
    input  logic            pen,
    input  logic            even,
    input  logic [BT_W-1:0] k,
    output logic            tx,
    output logic            TXRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            txrdy_q, txrdy_d;
    logic [7:0]      data_q, data_d;
    logic            eight_q, eight_d;
    logic            pen_q, pen_d;
    logic            even_q, even_d;
    logic [10:0]     shq_q, shq_d;
    logic [BT_W-1:0] btc_q, btc_d;
    logic [3:0]      bitc_q, bitc_d;

    logic [7:0]      par_bits;
    logic            par_xor;
    logic            parity;
    logic [10:0]     frame;
    logic            btu;
    logic [3:0]      bitc_inc;

    // data[7] only contributes to parity in 8-bit mode
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_par
            if (gi == 7) begin : g_msb
                assign par_bits[gi] = data_q[gi] & eight_q;
            end else begin : g_lsb
                assign par_bits[gi] = data_q[gi];
            end
        end
    endgenerate

    assign par_xor = ^par_bits;
    assign parity  = even_q ? par_xor : ~par_xor;

    // Frame image, bit index = transmit order; unused slots become extra stop bits
    assign frame[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_frame
            assign frame[gi] = data_q[gi-1];
        end
    endgenerate
    assign frame[8]  = eight_q ? data_q[7] : (pen_q ? parity : 1'b1);
    assign frame[9]  = (eight_q & pen_q) ? parity : 1'b1;
    assign frame[10] = 1'b1;

    assign btu      = (btc_q == k);
    assign bitc_inc = bitc_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            txrdy_q <= 1'b1;
            data_q  <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            even_q  <= 1'b0;
            shq_q   <= '1;
            btc_q   <= '0;
            bitc_q  <= '0;
        end else begin
            state_q <= state_d;
            txrdy_q <= txrdy_d;
            data_q  <= data_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            even_q  <= even_d;
            shq_q   <= shq_d;
            btc_q   <= btc_d;
            bitc_q  <= bitc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        txrdy_d = txrdy_q;
        data_d  = data_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        even_d  = even_q;
        shq_d   = shq_q;
        btc_d   = btc_q;
        bitc_d  = bitc_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d  = out_data;
                    eight_d = eight;
                    pen_d   = pen;
                    even_d  = even;
                    txrdy_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shq_d   = frame;
                btc_d   = '0;
                bitc_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (btu) begin
                    btc_d  = '0;
                    bitc_d = bitc_inc;
                    // Ones shift in behind the frame, so the line is already idle-high when done
                    shq_d  = {1'b1, shq_q[10:1]};
                    if (bitc_inc == 4'd11) begin
                        state_d = IDLE;
                        txrdy_d = 1'b1;
                    end
                end else begin
                    btc_d = btc_q + BT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx    = shq_q[0];
    assign TXRDY = txrdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a cycle-level frame model checked every cycle, plus
// directed frames whose bit patterns and timing are pinned by hand-computed literals.
module tb_uart_tx_engine;

    localparam int BT_W = 19;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [7:0]      out_data;
    logic            eight;
    logic            pen;
    logic            even;
    logic [BT_W-1:0] k;
    logic            tx;
    logic            TXRDY;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    uart_tx_engine #(.BT_W(BT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .out_data (out_data),
        .eight    (eight),
        .pen      (pen),
        .even     (even),
        .k        (k),
        .tx       (tx),
        .TXRDY    (TXRDY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame as a list: start bit, data bits LSB first, optional parity, then stop bits to 11
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic ev);
        bit q[$];
        int ones;
        int nd;
        logic [10:0] r;
        ones = 0;
        nd   = e ? 8 : 7;
        q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            q.push_back(d[i]);
            ones = ones + int'(d[i]);
        end
        if (p) q.push_back(ev ? bit'(ones % 2) : bit'(1 - (ones % 2)));
        while (q.size() < 11) q.push_back(1'b1);
        for (int i = 0; i < 11; i++) r[i] = q[i];
        return r;
    endfunction

    // Model: n counts edges since the accepting edge; the line is busy for n = 0 .. 11*(k+1)
    bit          m_busy = 1'b0;
    int          m_n = 0;
    int          m_k = 0;
    logic [10:0] m_frame = '1;
    int          m_frames = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_n    <= 0;
        end else if (m_busy) begin
            if (m_n == 11 * (m_k + 1)) m_busy <= 1'b0;
            else m_n <= m_n + 1;
        end else if (load) begin
            m_busy   <= 1'b1;
            m_n      <= 0;
            m_k      <= int'(k);
            m_frame  <= model_frame(out_data, eight, pen, even);
            m_frames <= m_frames + 1;
            $display("frame %0d: data=%02h eight=%0d pen=%0d even=%0d k=%0d",
                     m_frames, out_data, eight, pen, even, k);
        end
    end

    always @(negedge clk) begin
        logic exp_tx;
        if (chk_en) begin
            if (!m_busy || m_n == 0) exp_tx = 1'b1;
            else exp_tx = m_frame[(m_n - 1) / (m_k + 1)];
            chk("model_tx", 32'(tx), 32'(exp_tx));
            chk("model_rdy", 32'(TXRDY), 32'(!m_busy));
        end
    end

    // Starts at an idle negedge, ends at the negedge just after TXRDY rises
    task automatic run_frame(input string nm, input logic [7:0] d, input logic e,
                             input logic p, input logic ev, input int kk,
                             input logic [10:0] exp_bits, input bit disturb);
        int len;
        len      = 11 * (kk + 1);
        out_data = d;
        eight    = e;
        pen      = p;
        even     = ev;
        k        = BT_W'(kk);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk({nm, "_rdy_fall"}, 32'(TXRDY), 32'd0);
        chk({nm, "_load_cycle_tx"}, 32'(tx), 32'd1);
        for (int n = 1; n <= len + 1; n++) begin
            @(negedge clk);
            if (disturb && n == 3) begin
                load     = 1'b1;
                out_data = 8'hFF;
                eight    = ~e;
                pen      = ~p;
            end
            if (disturb && n == 4) load = 1'b0;
            if (n <= len && ((n - 1) % (kk + 1)) == 0)
                chk($sformatf("%s_bit%0d", nm, (n - 1) / (kk + 1)), 32'(tx),
                    32'(exp_bits[(n - 1) / (kk + 1)]));
            if (n == len) chk({nm, "_rdy_still_low"}, 32'(TXRDY), 32'd0);
            if (n == len + 1) begin
                chk({nm, "_rdy_rise"}, 32'(TXRDY), 32'd1);
                chk({nm, "_stop_tx"}, 32'(tx), 32'd1);
            end
        end
        eight = e;
        pen   = p;
        $display("directed %s: data=%02h k=%0d done", nm, d, kk);
    endtask

    initial begin
        int waited;
        rst      = 1'b1;
        load     = 1'b0;
        out_data = 8'h00;
        eight    = 1'b1;
        pen      = 1'b0;
        even     = 1'b0;
        k        = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset pulse while idle, then a long quiet line
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("idle_rst_tx", 32'(tx), 32'd1);
        chk("idle_rst_rdy", 32'(TXRDY), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("quiet_tx", 32'(tx), 32'd1);

        run_frame("a5_k4", 8'hA5, 1'b1, 1'b0, 1'b0, 4, 11'h74A, 1'b0);
        run_frame("p_even", 8'h03, 1'b1, 1'b1, 1'b1, 2, 11'h406, 1'b0);
        run_frame("p_odd", 8'h03, 1'b1, 1'b1, 1'b0, 2, 11'h606, 1'b0);
        run_frame("seven", 8'h81, 1'b0, 1'b1, 1'b1, 1, 11'h702, 1'b0);
        run_frame("disturb", 8'h3C, 1'b1, 1'b0, 1'b0, 3, 11'h678, 1'b1);
        repeat (5) @(negedge clk);
        chk("no_second_frame", 32'(TXRDY), 32'd1);

        // Back-to-back at k=0: load right after TXRDY is seen high
        run_frame("b2b_first", 8'h55, 1'b1, 1'b1, 1'b0, 0, 11'h6AA, 1'b0);
        run_frame("b2b_second", 8'hA5, 1'b1, 1'b0, 1'b0, 0, 11'h74A, 1'b0);

        // Abort mid-frame: outputs must recover before the next clock edge
        @(negedge clk);
        out_data = 8'h00;
        k        = BT_W'(3);
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_rdy", 32'(TXRDY), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic, including loads and config churn while busy
        repeat (4000) begin
            @(negedge clk);
            load     = ($urandom_range(0, 5) == 0);
            out_data = 8'($urandom);
            eight    = 1'($urandom);
            pen      = 1'($urandom);
            even     = 1'($urandom);
            if (!m_busy && !load)
                k = ($urandom_range(0, 9) == 0) ? BT_W'($urandom_range(10, 20))
                                                 : BT_W'($urandom_range(0, 6));
        end
        load   = 1'b0;
        waited = 0;
        while ((m_busy || !TXRDY) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) chk("drain_timeout", 32'(TXRDY), 32'd1);
        chk("frames_random", 32'(m_frames > 20), 32'd1);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
